spi_receiver: RTL and testbench

Serial-to-parallel receiving end of the team's 24-bit DAC-style SPI link (sdi/sclk/sync_n, MSB first). It oversamples the three SPI lines in the system clock domain, assembles one word per sync_n frame, and pushes complete, correctly framed words into the existing fifo_buffer through its write port. Typical use is loopback verification of spi_transmitter, or as a slave front-end that fills a FIFO from an external SPI master.

---
 rtl/spi_receiver_if.sv | 26 ++
 rtl/spi_receiver.sv | 127 ++++++++++++
 tb/tb_spi_receiver.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_receiver_if.sv
// Signal bundle between an SPI master / FIFO environment and spi_receiver.
// The master modport drives the SPI pins and FIFO status; the slave modport is the receiver.
interface spi_receiver_if #(
  parameter int WORD_WIDTH = 24
);
  logic                  sdi;
  logic                  sclk;
  logic                  sync_n;
  logic                  fifo_full;
  logic                  clear_errors;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  write_data;
  logic                  frame_error;
  logic                  overflow;
  logic                  rx_busy;

  modport master (
    output sdi, sclk, sync_n, fifo_full, clear_errors,
    input  data_out, write_data, frame_error, overflow, rx_busy
  );

  modport slave (
    input  sdi, sclk, sync_n, fifo_full, clear_errors,
    output data_out, write_data, frame_error, overflow, rx_busy
  );
endinterface

// File: rtl/spi_receiver.sv
// Oversampling SPI slave receiver: assembles one MSB-first word per sync_n frame
// and pushes correctly framed words into a FIFO write port.
module spi_receiver #(
  parameter int WORD_WIDTH     = 24,
  parameter bit SAMPLE_ON_FALL = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  spi_receiver_if.slave bus
);
  localparam int CW = $clog2(WORD_WIDTH + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  // [0],[1] synchronizer, [2] previous value for edge detection
  logic [2:0] sclk_q, sync_q;
  logic [1:0] sdi_q;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         bit_count_q, bit_count_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic                  ferr_q, ferr_d;
  logic                  ovf_q, ovf_d;

  logic sclk_rise, sclk_fall, sample_edge, sync_fall, sync_rise;
  logic ferr_set, ovf_set;

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign sample_edge = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
  assign sync_fall   = ~sync_q[1] & sync_q[2];
  assign sync_rise   = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      sync_q <= '1;
      sdi_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.sclk};
      sync_q <= {sync_q[1:0], bus.sync_n};
      sdi_q  <= {sdi_q[0], bus.sdi};
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    data_d      = data_q;
    write_d     = 1'b0;
    ferr_set    = 1'b0;
    ovf_set     = 1'b0;
    case (state_q)
      IDLE: begin
        bit_count_d = '0;
        if (sync_fall) begin
          state_d = SHIFT;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (sync_rise) begin
          state_d = CHECK;
        end else if (sample_edge) begin
          shift_d = {shift_q[WORD_WIDTH-2:0], sdi_q[1]};
          // saturate so an over-long frame can never wrap back to a valid count
          if (bit_count_q != CW'(WORD_WIDTH + 1))
            bit_count_d = bit_count_q + CW'(1);
        end
      end
      CHECK: begin
        if (bit_count_q == CW'(WORD_WIDTH)) begin
          if (!bus.fifo_full) begin
            data_d  = shift_q;
            write_d = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end else begin
          ferr_set = 1'b1;
        end
        // a new frame starting during CHECK goes straight to SHIFT
        if (sync_fall) begin
          state_d     = SHIFT;
          shift_d     = '0;
          bit_count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ferr_d = ferr_set | (ferr_q & ~bus.clear_errors);
    ovf_d  = ovf_set  | (ovf_q  & ~bus.clear_errors);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      write_q     <= write_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.write_data  = write_q;
  assign bus.frame_error = ferr_q;
  assign bus.overflow    = ovf_q;
  assign bus.rx_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: drives SPI frames on the pins and checks
// FIFO writes, error flags and reset behaviour against hand-computed values.
module tb_spi_receiver;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  logic [W-1:0] wq[$];
  logic         prev_wr = 1'b0;
  logic         consec = 1'b0;

  spi_receiver_if #(.WORD_WIDTH(W)) bus ();

  spi_receiver #(.WORD_WIDTH(W), .SAMPLE_ON_FALL(1'b1)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.write_data === 1'b1) begin
      wq.push_back(bus.data_out);
      if (prev_wr) consec = 1'b1;
    end
    prev_wr = (bus.write_data === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_low();
    bus.sync_n = 1'b0;
    cycles(4);
  endtask

  // MSB first: data set while sclk high, sampled by the receiver on the fall
  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.sclk = 1'b1;
      bus.sdi  = word[i];
      cycles(3);
      bus.sclk = 1'b0;
      cycles(3);
    end
  endtask

  task automatic frame(input logic [31:0] word, input int nbits);
    sync_low();
    send_bits(word, nbits);
    bus.sync_n = 1'b1;
    cycles(8);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.sdi          = 1'b0;
    bus.sclk         = 1'b0;
    bus.sync_n       = 1'b1;
    bus.fifo_full    = 1'b0;
    bus.clear_errors = 1'b0;
    cycles(3);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_write", 32'(bus.write_data), 32'h0);
    check("rst_ferr", 32'(bus.frame_error), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'h0);
    check("rst_busy", 32'(bus.rx_busy), 32'h0);
    rst_n = 1'b1;
    cycles(3);

    // nominal frame with exact write timing
    sync_low();
    check("nom_busy", 32'(bus.rx_busy), 32'h1);
    send_bits(32'hEA3A35, 24);
    bus.sync_n = 1'b1;
    cycles(3);
    check("nom_wr_early", 32'(bus.write_data), 32'h0);
    cycles(1);
    check("nom_wr_pulse", 32'(bus.write_data), 32'h1);
    check("nom_data", 32'(bus.data_out), 32'hEA3A35);
    cycles(1);
    check("nom_wr_end", 32'(bus.write_data), 32'h0);
    check("nom_hold", 32'(bus.data_out), 32'hEA3A35);
    cycles(4);
    check("nom_count", 32'(wq.size()), 32'd1);
    check("nom_ferr", 32'(bus.frame_error), 32'h0);
    check("nom_ovf", 32'(bus.overflow), 32'h0);
    check("nom_idle", 32'(bus.rx_busy), 32'h0);

    // short then long frame
    frame(32'h000ABCDE, 20);
    check("short_count", 32'(wq.size()), 32'd1);
    check("short_ferr", 32'(bus.frame_error), 32'h1);
    frame(32'h02AAAAAA, 26);
    check("long_count", 32'(wq.size()), 32'd1);
    check("long_ferr", 32'(bus.frame_error), 32'h1);
    bus.clear_errors = 1'b1;
    cycles(1);
    bus.clear_errors = 1'b0;
    cycles(1);
    check("clr_ferr", 32'(bus.frame_error), 32'h0);
    frame(32'h123456, 24);
    check("after_err_count", 32'(wq.size()), 32'd2);
    check("after_err_data", 32'(wq[1]), 32'h123456);
    check("after_err_ferr", 32'(bus.frame_error), 32'h0);

    // FIFO full drops the word and flags overflow
    bus.fifo_full = 1'b1;
    frame(32'hABCDEF, 24);
    check("full_count", 32'(wq.size()), 32'd2);
    check("full_ovf", 32'(bus.overflow), 32'h1);
    check("full_data_held", 32'(bus.data_out), 32'h123456);
    bus.fifo_full = 1'b0;
    frame(32'h000001, 24);
    check("unfull_count", 32'(wq.size()), 32'd3);
    check("unfull_data", 32'(wq[2]), 32'h000001);
    check("ovf_sticky", 32'(bus.overflow), 32'h1);
    bus.clear_errors = 1'b1;
    cycles(1);
    bus.clear_errors = 1'b0;
    cycles(1);
    check("clr_ovf", 32'(bus.overflow), 32'h0);

    // asynchronous reset mid-frame, then a fresh frame
    sync_low();
    send_bits(32'hFFF, 12);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(bus.data_out), 32'h0);
    check("mid_rst_busy", 32'(bus.rx_busy), 32'h0);
    check("mid_rst_write", 32'(bus.write_data), 32'h0);
    bus.sync_n = 1'b1;
    bus.sclk   = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    check("post_rst_idle", 32'(bus.rx_busy), 32'h0);
    frame(32'hFFFFFF, 24);
    check("post_rst_count", 32'(wq.size()), 32'd4);
    check("post_rst_data", 32'(wq[3]), 32'hFFFFFF);

    // sclk toggling while deselected, then back-to-back frames with 2-cycle gap
    send_bits(32'h5, 3);
    sync_low();
    send_bits(32'h800001, 24);
    bus.sync_n = 1'b1;
    cycles(2);
    sync_low();
    send_bits(32'h7FFFFE, 24);
    bus.sync_n = 1'b1;
    cycles(2);
    send_bits(32'h3, 2);
    cycles(8);
    check("b2b_count", 32'(wq.size()), 32'd6);
    check("b2b_first", 32'(wq[4]), 32'h800001);
    check("b2b_second", 32'(wq[5]), 32'h7FFFFE);
    check("b2b_ferr", 32'(bus.frame_error), 32'h0);
    check("b2b_ovf", 32'(bus.overflow), 32'h0);
    check("no_consec_write", 32'(consec), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
